// File: rtl/instruction_controller_pkg.sv
// Shared constants, state encoding and instruction classes for the Simple RISC Machine control unit.
// Optional illegal-encoding flag is enabled by defining CTRL_ILLEGAL_FLAG_EN.
package instruction_controller_pkg;

    localparam int WORD_W = 16;
    localparam int RN_W   = 3;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    localparam logic [1:0] SUB_MOV_IMM = 2'b10;
    localparam logic [1:0] SUB_MOV_REG = 2'b00;
    localparam logic [1:0] SUB_ADD     = 2'b00;
    localparam logic [1:0] SUB_CMP     = 2'b01;
    localparam logic [1:0] SUB_AND     = 2'b10;
    localparam logic [1:0] SUB_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_NOT_B = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } instr_class_t;

    typedef struct packed {
        logic [RN_W-1:0] rn;
        logic [RN_W-1:0] rd;
        logic [1:0]      sh;
        logic [RN_W-1:0] rm;
    } instr_fields_t;

    function automatic logic [WORD_W-1:0] sext5(input logic [4:0] imm);
        return WORD_W'($signed(imm));
    endfunction

    function automatic logic [WORD_W-1:0] sext8(input logic [7:0] imm);
        return WORD_W'($signed(imm));
    endfunction

endpackage

// File: rtl/instruction_controller_if.sv
// Bus between the instruction source / datapath and the control unit.
// The illegal output exists only when CTRL_ILLEGAL_FLAG_EN is defined.
interface instruction_controller_if;
    import instruction_controller_pkg::*;

    logic              load;
    logic              s;
    logic [WORD_W-1:0] in;
    logic              w;
    logic [RN_W-1:0]   readnum;
    logic [RN_W-1:0]   writenum;
    logic [1:0]        vsel;
    logic              loada;
    logic              loadb;
    logic              asel;
    logic              bsel;
    logic [1:0]        ALUop;
    logic [1:0]        shift;
    logic              loadc;
    logic              loads;
    logic              write;
    logic [WORD_W-1:0] sximm5;
    logic [WORD_W-1:0] sximm8;
`ifdef CTRL_ILLEGAL_FLAG_EN
    logic              illegal;
`endif

    modport slave (
`ifdef CTRL_ILLEGAL_FLAG_EN
        output illegal,
`endif
        input  load, s, in,
        output w, readnum, writenum, vsel, loada, loadb, asel, bsel,
        output ALUop, shift, loadc, loads, write, sximm5, sximm8
    );

    modport master (
`ifdef CTRL_ILLEGAL_FLAG_EN
        input  illegal,
`endif
        output load, s, in,
        input  w, readnum, writenum, vsel, loada, loadb, asel, bsel,
        input  ALUop, shift, loadc, loads, write, sximm5, sximm8
    );

endinterface

// File: rtl/instruction_controller_instr_decoder.sv
// Combinational decode of the instruction register: register fields, immediates,
// instruction class and legality.
module instruction_controller_instr_decoder
    import instruction_controller_pkg::*;
(
    input  logic [WORD_W-1:0] ir,
    output instr_class_t      cls,
    output instr_fields_t     fields,
    output logic              legal,
    output logic [WORD_W-1:0] sximm5,
    output logic [WORD_W-1:0] sximm8
);

    logic [2:0] op;
    logic [1:0] sub;

    assign op  = ir[15:13];
    assign sub = ir[12:11];

    assign fields.rn = ir[10:8];
    assign fields.rd = ir[7:5];
    assign fields.sh = ir[4:3];
    assign fields.rm = ir[2:0];

    assign sximm5 = sext5(ir[4:0]);
    assign sximm8 = sext8(ir[7:0]);

    // Anything outside the two supported opcode groups stays CLS_ILLEGAL
    always_comb begin
        cls = CLS_ILLEGAL;
        case (op)
            OP_MOV: begin
                if (sub == SUB_MOV_IMM)
                    cls = CLS_MOV_IMM;
                else if (sub == SUB_MOV_REG)
                    cls = CLS_MOV_REG;
            end
            OP_ALU: begin
                case (sub)
                    SUB_ADD: cls = CLS_ADD;
                    SUB_CMP: cls = CLS_CMP;
                    SUB_AND: cls = CLS_AND;
                    SUB_MVN: cls = CLS_MVN;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/instruction_controller.sv
// Moore control FSM for the Simple RISC Machine datapath; one instruction per start pulse.
// Define CTRL_ILLEGAL_FLAG_EN to add a sticky illegal-encoding flag output.
module instruction_controller
    import instruction_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    instruction_controller_if.slave ctrl
);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] ir;
    instr_class_t      cls;
    instr_fields_t     fields;
    logic              legal;
    logic [WORD_W-1:0] sximm5;
    logic [WORD_W-1:0] sximm8;

    instruction_controller_instr_decoder u_instr_decoder (
        .ir     (ir),
        .cls    (cls),
        .fields (fields),
        .legal  (legal),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    assign ctrl.sximm5 = sximm5;
    assign ctrl.sximm8 = sximm8;

    // IR only moves in WAIT so an executing instruction never sees its encoding change
    always_ff @(posedge clk) begin
        if (reset)
            ir <= '0;
        else if (state == S_WAIT && ctrl.load)
            ir <= ctrl.in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_WAIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT:   next_state = ctrl.s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (!legal)
                    next_state = S_WAIT;
                else begin
                    case (cls)
                        CLS_MOV_IMM:                  next_state = S_WR_IMM;
                        CLS_ADD, CLS_CMP, CLS_AND:    next_state = S_GET_A;
                        CLS_MOV_REG, CLS_MVN:         next_state = S_GET_B;
                        default:                      next_state = S_WAIT;
                    endcase
                end
            end
            S_GET_A:  next_state = S_GET_B;
            S_GET_B:  next_state = S_ALU;
            S_ALU:    next_state = (cls == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: next_state = S_WAIT;
            S_WR_IMM: next_state = S_WAIT;
            default:  next_state = S_WAIT;
        endcase
    end

    // MOV Rd,Rm reuses the adder with A forced to zero so the shifted B passes through
    always_comb begin
        ctrl.w        = 1'b0;
        ctrl.readnum  = '0;
        ctrl.writenum = '0;
        ctrl.vsel     = VSEL_C;
        ctrl.loada    = 1'b0;
        ctrl.loadb    = 1'b0;
        ctrl.asel     = 1'b0;
        ctrl.bsel     = 1'b0;
        ctrl.ALUop    = ALU_ADD;
        ctrl.shift    = 2'b00;
        ctrl.loadc    = 1'b0;
        ctrl.loads    = 1'b0;
        ctrl.write    = 1'b0;
        case (state)
            S_WAIT: ctrl.w = 1'b1;
            S_GET_A: begin
                ctrl.readnum = fields.rn;
                ctrl.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl.readnum = fields.rm;
                ctrl.loadb   = 1'b1;
            end
            S_ALU: begin
                ctrl.shift = fields.sh;
                case (cls)
                    CLS_MOV_REG: begin
                        ctrl.ALUop = ALU_ADD;
                        ctrl.asel  = 1'b1;
                        ctrl.loadc = 1'b1;
                    end
                    CLS_CMP: begin
                        ctrl.ALUop = ALU_SUB;
                        ctrl.loads = 1'b1;
                    end
                    CLS_AND: begin
                        ctrl.ALUop = ALU_AND;
                        ctrl.loadc = 1'b1;
                    end
                    CLS_MVN: begin
                        ctrl.ALUop = ALU_NOT_B;
                        ctrl.loadc = 1'b1;
                    end
                    default: begin
                        ctrl.ALUop = ALU_ADD;
                        ctrl.loadc = 1'b1;
                    end
                endcase
            end
            S_WR_REG: begin
                ctrl.writenum = fields.rd;
                ctrl.vsel     = VSEL_C;
                ctrl.write    = 1'b1;
            end
            S_WR_IMM: begin
                ctrl.writenum = fields.rn;
                ctrl.vsel     = VSEL_IMM8;
                ctrl.write    = 1'b1;
            end
            default: ctrl.w = 1'b0;
        endcase
    end

`ifdef CTRL_ILLEGAL_FLAG_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && !legal)
            illegal_q <= 1'b1;
    end

    assign ctrl.illegal = illegal_q;
`endif

endmodule

// File: tb/tb_instruction_controller.sv
// Testbench for instruction_controller: directed instructions with literal expectations plus
// randomized load/s/reset traffic checked every cycle against an instruction-level model.
module tb_instruction_controller;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic       loadc;
        logic       loads;
        logic       write;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_controller_if bus();

    instruction_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: architectural IR plus the list of control cycles still to be issued
    logic [15:0] m_ir = '0;
    ctl_t        exp_q[$];
    bit          ill_pending = 1'b0;
    bit          m_ill = 1'b0;
    bit          model_live = 1'b0;
    ctl_t        exp_ctl;
    logic [63:0] exp_vec;
    logic [63:0] act_vec;
    logic        exp_ill;
    logic        act_ill;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [15:0] word);
        bus.load = ld;
        bus.s    = st;
        bus.in   = word;
    endtask

    function automatic logic [15:0] sx5(input logic [15:0] ir);
        return {{11{ir[4]}}, ir[4:0]};
    endfunction

    function automatic logic [15:0] sx8(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    // Control cycles an instruction needs, starting with its decode cycle
    function automatic void build_sequence(input logic [15:0] ir);
        logic [2:0] op  = ir[15:13];
        logic [1:0] sub = ir[12:11];
        ctl_t r;
        r = '0;
        exp_q.push_back(r);
        if (op == 3'b110 && sub == 2'b10) begin
            r = '0; r.writenum = ir[10:8]; r.vsel = 2'b10; r.write = 1'b1; exp_q.push_back(r);
        end else if (op == 3'b110 && sub == 2'b00) begin
            r = '0; r.readnum = ir[2:0]; r.loadb = 1'b1; exp_q.push_back(r);
            r = '0; r.asel = 1'b1; r.shift = ir[4:3]; r.loadc = 1'b1; exp_q.push_back(r);
            r = '0; r.writenum = ir[7:5]; r.write = 1'b1; exp_q.push_back(r);
        end else if (op == 3'b101) begin
            if (sub != 2'b11) begin
                r = '0; r.readnum = ir[10:8]; r.loada = 1'b1; exp_q.push_back(r);
            end
            r = '0; r.readnum = ir[2:0]; r.loadb = 1'b1; exp_q.push_back(r);
            r = '0; r.aluop = sub; r.shift = ir[4:3];
            if (sub == 2'b01) r.loads = 1'b1; else r.loadc = 1'b1;
            exp_q.push_back(r);
            if (sub != 2'b01) begin
                r = '0; r.writenum = ir[7:5]; r.write = 1'b1; exp_q.push_back(r);
            end
        end else begin
            ill_pending = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ir = '0;
            exp_q.delete();
            ill_pending = 1'b0;
            m_ill = 1'b0;
            model_live = 1'b1;
        end else if (exp_q.size() == 0) begin
            if (bus.load) m_ir = bus.in;
            if (bus.s) build_sequence(m_ir);
        end else begin
            void'(exp_q.pop_front());
            if (ill_pending) begin
                m_ill = 1'b1;
                ill_pending = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            exp_ctl = '0;
            if (exp_q.size() == 0) exp_ctl.w = 1'b1;
            else exp_ctl = exp_q[0];
`ifdef CTRL_ILLEGAL_FLAG_EN
            exp_ill = m_ill;
            act_ill = bus.illegal;
`else
            exp_ill = 1'b0;
            act_ill = 1'b0;
`endif
            exp_vec = {11'd0, exp_ill, sx8(m_ir), sx5(m_ir), exp_ctl};
            act_vec = {11'd0, act_ill, bus.sximm8, bus.sximm5, bus.w, bus.readnum, bus.writenum,
                       bus.vsel, bus.loada, bus.loadb, bus.asel, bus.bsel, bus.ALUop, bus.shift,
                       bus.loadc, bus.loads, bus.write};
            checkOutput("cycle_outputs", act_vec, exp_vec);
        end
    end

    // Issues one instruction from WAIT and records what the DUT did until w returns
    task automatic runInstr(input logic [15:0] word, input bit midload, output int cycles,
                            output bit saw_write, output logic [2:0] wr_num, output logic [1:0] wr_vsel,
                            output logic [15:0] wr_sx8, output bit saw_loads, output logic [1:0] alu_op,
                            output logic [1:0] alu_shift);
        saw_write = 0; saw_loads = 0; wr_num = '0; wr_vsel = '0; wr_sx8 = '0; alu_op = '0; alu_shift = '0;
        applyStimulus(1'b1, 1'b1, word);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, word);
        cycles = 1;
        while (bus.w !== 1'b1 && cycles < 20) begin
            if (bus.write === 1'b1) begin
                saw_write = 1; wr_num = bus.writenum; wr_vsel = bus.vsel; wr_sx8 = bus.sximm8;
            end
            if (bus.loadc === 1'b1 || bus.loads === 1'b1) begin
                alu_op = bus.ALUop; alu_shift = bus.shift;
            end
            if (bus.loads === 1'b1) saw_loads = 1;
            if (midload && cycles == 2) applyStimulus(1'b1, 1'b0, 16'hD14C);
            @(posedge clk); #1;
            applyStimulus(1'b0, 1'b0, word);
            cycles++;
        end
        if (cycles >= 20) checkOutput("w_timeout", 64'(cycles), 64'd0);
    endtask

    int          cyc;
    bit          sw;
    bit          sl;
    logic [2:0]  wn;
    logic [1:0]  wv;
    logic [15:0] w8;
    logic [1:0]  aop;
    logic [1:0]  ash;
    logic [15:0] rnd;

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_w", 64'(bus.w), 64'd1);
        checkOutput("reset_write", 64'(bus.write), 64'd0);
        checkOutput("reset_sximm8", 64'(bus.sximm8), 64'd0);

        runInstr(16'hD012, 0, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("movimm_latency", 64'(cyc), 64'd3);
        checkOutput("movimm_write", 64'(sw), 64'd1);
        checkOutput("movimm_writenum", 64'(wn), 64'd0);
        checkOutput("movimm_vsel", 64'(wv), 64'd2);
        checkOutput("movimm_sximm8", 64'(w8), 64'd18);

        runInstr(16'hA049, 0, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("add_latency", 64'(cyc), 64'd6);
        checkOutput("add_writenum", 64'(wn), 64'd2);
        checkOutput("add_shift", 64'(ash), 64'd1);
        checkOutput("add_aluop", 64'(aop), 64'd0);

        runInstr(16'hA801, 0, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("cmp_latency", 64'(cyc), 64'd5);
        checkOutput("cmp_no_write", 64'(sw), 64'd0);
        checkOutput("cmp_loads", 64'(sl), 64'd1);
        checkOutput("cmp_aluop", 64'(aop), 64'd1);

        runInstr(16'hB8C5, 0, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("mvn_latency", 64'(cyc), 64'd5);
        checkOutput("mvn_writenum", 64'(wn), 64'd6);
        checkOutput("mvn_aluop", 64'(aop), 64'd3);

        runInstr(16'hE000, 0, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("illegal_latency", 64'(cyc), 64'd2);
        checkOutput("illegal_no_write", 64'(sw), 64'd0);
`ifdef CTRL_ILLEGAL_FLAG_EN
        checkOutput("illegal_flag", 64'(bus.illegal), 64'd1);
`endif

        runInstr(16'hA049, 1, cyc, sw, wn, wv, w8, sl, aop, ash);
        checkOutput("midload_latency", 64'(cyc), 64'd6);
        checkOutput("midload_writenum", 64'(wn), 64'd2);
        checkOutput("midload_ir_kept", 64'(bus.sximm8), 64'h0049);

        applyStimulus(1'b1, 1'b1, 16'hA049);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'hA049);
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_no_write", 64'(bus.write), 64'd0);
            @(posedge clk); #1;
        end
        checkOutput("abort_in_alu", 64'(bus.loadc), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_w", 64'(bus.w), 64'd1);
        checkOutput("abort_write", 64'(bus.write), 64'd0);
        checkOutput("abort_ir_cleared", 64'(bus.sximm8), 64'd0);
`ifdef CTRL_ILLEGAL_FLAG_EN
        checkOutput("abort_illegal_cleared", 64'(bus.illegal), 64'd0);
`endif

        for (int i = 0; i < 2000; i++) begin
            rnd = 16'($urandom);
            case ($urandom_range(0, 4))
                0: rnd[15:11] = 5'b11010;
                1: rnd[15:11] = 5'b11000;
                2, 3: rnd[15:13] = 3'b101;
                default: ;
            endcase
            reset = ($urandom_range(0, 59) == 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, rnd);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        repeat (8) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
